dma_multi_ch_regs: RTL and testbench
====================================

DMA_MULTI_CH_REGS -- requirements
Module: dma_multi_ch_regs

Interface
REQ-001 SHALL have parameter NUM_CH, default 4, number of DMA channels (1..16).
REQ-002 SHALL have parameter DATA_W, default 32, width of the CPU data bus and of every register.
REQ-003 SHALL have port clk  input  1  single clock; all logic on its rising edge.
REQ-004 SHALL have port reset  input  1  synchronous, active-high reset.
REQ-005 SHALL have ports cpu_wr_en and cpu_rd_en, each input 1, CPU write and read strobes.
REQ-006 SHALL have ports cpu_addr input 32, cpu_wr_data input DATA_W, and cpu_rd_data output DATA_W.
REQ-007 SHALL have ports src_addr, dstn_addr, count and ctrl_sig, each output NUM_CH*DATA_W, holding the per-channel registers packed with channel 0 in the LSBs.
REQ-008 SHALL have ports ch_req output NUM_CH, ch_grant input NUM_CH and ch_done input NUM_CH, forming the engine handshake.
REQ-009 SHALL have port irq, output 1, the interrupt line.

Function
REQ-010 SHALL decode addresses as follows: cpu_addr[8]=0 selects the channel block, with channel = cpu_addr[7:4] and offset = cpu_addr[3:0] (0x0 src, 0x4 count, 0x8 ctrl, 0xC dstn).
REQ-011 SHALL decode cpu_addr[8]=1 as the global block: 0x100 STATUS (RO), 0x104 DONE (W1C), 0x108 ERR (W1C), 0x10C IRQ_EN (RW); bit n of each refers to channel n.
REQ-012 SHALL treat any channel index >= NUM_CH and any unmapped offset as follows: writes are ignored and reads return 0.
REQ-013 SHALL register cpu_rd_data, presenting it one cycle after cpu_rd_en is sampled and driving 0 in every other cycle.
REQ-014 SHALL give each channel an FSM with states IDLE, PEND and BUSY.
REQ-015 SHALL move a channel from IDLE to PEND on a ctrl write with bit0=1; ctrl_sig bit0 is then held at 1.
REQ-016 SHALL hold ch_req[n] high exactly while channel n is in PEND.
REQ-017 SHALL move a channel from PEND to BUSY on ch_grant[n]; ch_req[n] drops in the following cycle.
REQ-018 SHALL move a channel from BUSY to IDLE on ch_done[n], clearing ctrl_sig bit0 and setting DONE[n] in the same edge.
REQ-019 SHALL cancel a PEND channel back to IDLE on a ctrl write with bit0=0, with DONE[n] left unchanged.
REQ-020 SHALL ignore all other writes to a channel while it is in PEND or BUSY, and SHALL set ERR[n] for each such write.
REQ-021 SHALL ignore ch_grant in IDLE and BUSY, and ch_done in IDLE and PEND.
REQ-022 SHALL report in STATUS bit n = (state!=IDLE), bit 16+n = (state==BUSY), with all other bits 0.
REQ-023 SHALL give priority to a hardware set of DONE or ERR over a W1C clear of the same bit arriving in the same cycle.
REQ-024 SHALL drive irq = |(DONE & IRQ_EN) registered, so irq is valid one cycle after its cause.
REQ-025 SHALL give a simultaneous CPU write and read in the same cycle read-old-data semantics: the read returns the pre-write value.

Reset
REQ-026 SHALL, on reset, clear every register, DONE, ERR, IRQ_EN, cpu_rd_data, ch_req and irq to 0, and return every FSM to IDLE.
REQ-027 SHALL let reset override any in-flight state; a ch_done arriving in the reset cycle is lost.

Configuration
REQ-028 SHALL, with DMA_ADDR_AUTOINC_EN defined, use ctrl bit2 (inc_src) and bit3 (inc_dstn) so that each ch_done advances src_addr/dstn_addr by count*(DATA_W/8), wrapping modulo 2^DATA_W, for chained transfers.
REQ-029 SHALL, without DMA_ADDR_AUTOINC_EN, treat ctrl bits 2-3 as plain storage with addresses never modified by hardware.

Structure
REQ-030 SHALL place the offset constants, global addresses, ctrl bit positions and the channel-state encoding in package dma_regs_pkg.
REQ-031 SHALL implement one channel (registers plus FSM) in sub-module dma_ch_regs, instantiated NUM_CH times via generate; the decode, global registers and irq stay in the top level.

Verification
REQ-032 SHALL verify the program path: write ch1 src=0x1000, count=0x10, dstn=0x2000, ctrl=0x1 -> ch_req[1]=1 and STATUS=0x0002; read 0x010 returns 0x1000 one cycle later.
REQ-033 SHALL verify the completion path: with IRQ_EN=0x2, pulse ch_grant[1] then ch_done[1] -> STATUS=0x0, DONE=0x2, irq=1; write 0x2 to 0x104 -> DONE=0, irq=0.
REQ-034 SHALL verify the busy-write protection: while ch0 is BUSY, write count=0x5 -> count unchanged and ERR=0x1.
REQ-035 SHALL verify the same-cycle W1C race: W1C of DONE[2] in the same cycle as ch_done[2] -> DONE[2] stays 1.
REQ-036 SHALL verify cancel and reset: cancel from PEND via ctrl=0 -> IDLE with ch_req=0; assert reset mid-BUSY -> all outputs 0 next cycle.
REQ-037 SHALL verify auto-increment, with DMA_ADDR_AUTOINC_EN defined: ctrl=0x5, src=0xFFFFFFF0, count=0x4, done -> src=0x0 (wrap).

Source files
------------

// File: rtl/dma_regs_pkg.sv
// Register map, ctrl bit positions and channel-state encoding shared by the DMA register block.
// Latency: n/a (constants only); backpressure: n/a.
package dma_regs_pkg;

  localparam logic [3:0] OFF_SRC   = 4'h0;
  localparam logic [3:0] OFF_COUNT = 4'h4;
  localparam logic [3:0] OFF_CTRL  = 4'h8;
  localparam logic [3:0] OFF_DSTN  = 4'hC;

  localparam logic [8:0] ADDR_STATUS = 9'h100;
  localparam logic [8:0] ADDR_DONE   = 9'h104;
  localparam logic [8:0] ADDR_ERR    = 9'h108;
  localparam logic [8:0] ADDR_IRQ_EN = 9'h10C;

  localparam int CTRL_EN_BIT       = 0;
  localparam int CTRL_INC_SRC_BIT  = 2;
  localparam int CTRL_INC_DSTN_BIT = 3;

  typedef enum logic [1:0] {
    CH_IDLE = 2'd0,
    CH_PEND = 2'd1,
    CH_BUSY = 2'd2
  } ch_state_e;

  function automatic logic off_mapped(input logic [3:0] off);
    return (off == OFF_SRC) || (off == OFF_COUNT) || (off == OFF_CTRL) || (off == OFF_DSTN);
  endfunction

endpackage

// File: rtl/dma_ch_regs.sv
// One DMA channel: src/count/ctrl/dstn registers plus IDLE/PEND/BUSY handshake FSM (DMA_ADDR_AUTOINC_EN adds address chaining).
// Latency: register/state updates and req take effect on the sampling edge; backpressure: none, illegal writes flag err_set.
module dma_ch_regs
  import dma_regs_pkg::*;
#(
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              wr_en,
  input  logic [3:0]        wr_off,
  input  logic [DATA_W-1:0] wr_data,
  input  logic              grant,
  input  logic              done,
  output logic [DATA_W-1:0] src_addr,
  output logic [DATA_W-1:0] dstn_addr,
  output logic [DATA_W-1:0] count,
  output logic [DATA_W-1:0] ctrl_sig,
  output logic              req,
  output ch_state_e         state,
  output logic              done_set,
  output logic              err_set
);

  ch_state_e         state_q, state_d;
  logic [DATA_W-1:0] src_q, src_d, dstn_q, dstn_d, count_q, count_d, ctrl_q, ctrl_d;
  logic              req_q, req_d;

`ifdef DMA_ADDR_AUTOINC_EN
  localparam logic [DATA_W-1:0] BYTES = DATA_W'(DATA_W / 8);
  logic [DATA_W-1:0] xfer_bytes;
  assign xfer_bytes = count_q * BYTES;
`endif

  always_comb begin
    state_d  = state_q;
    src_d    = src_q;
    dstn_d   = dstn_q;
    count_d  = count_q;
    ctrl_d   = ctrl_q;
    done_set = 1'b0;
    err_set  = 1'b0;
    unique case (state_q)
      CH_IDLE: begin
        if (wr_en) begin
          case (wr_off)
            OFF_SRC:   src_d   = wr_data;
            OFF_COUNT: count_d = wr_data;
            OFF_DSTN:  dstn_d  = wr_data;
            OFF_CTRL: begin
              ctrl_d = wr_data;
              if (wr_data[CTRL_EN_BIT]) state_d = CH_PEND;
            end
            default: ;
          endcase
        end
      end
      CH_PEND: begin
        // A cancel wins over a grant sampled in the same cycle.
        if (wr_en && wr_off == OFF_CTRL && !wr_data[CTRL_EN_BIT]) begin
          ctrl_d  = wr_data;
          state_d = CH_IDLE;
        end else begin
          err_set = wr_en && off_mapped(wr_off);
          if (grant) state_d = CH_BUSY;
        end
      end
      CH_BUSY: begin
        err_set = wr_en && off_mapped(wr_off);
        if (done) begin
          state_d             = CH_IDLE;
          ctrl_d[CTRL_EN_BIT] = 1'b0;
          done_set            = 1'b1;
`ifdef DMA_ADDR_AUTOINC_EN
          if (ctrl_q[CTRL_INC_SRC_BIT])  src_d  = src_q + xfer_bytes;
          if (ctrl_q[CTRL_INC_DSTN_BIT]) dstn_d = dstn_q + xfer_bytes;
`endif
        end
      end
      default: state_d = CH_IDLE;
    endcase
    req_d = (state_d == CH_PEND);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= CH_IDLE;
      src_q   <= '0;
      dstn_q  <= '0;
      count_q <= '0;
      ctrl_q  <= '0;
      req_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      src_q   <= src_d;
      dstn_q  <= dstn_d;
      count_q <= count_d;
      ctrl_q  <= ctrl_d;
      req_q   <= req_d;
    end
  end

  assign src_addr  = src_q;
  assign dstn_addr = dstn_q;
  assign count     = count_q;
  assign ctrl_sig  = ctrl_q;
  assign req       = req_q;
  assign state     = state_q;

endmodule

// File: rtl/dma_multi_ch_regs.sv
// Multi-channel DMA register file: CPU decode, per-channel instances, STATUS/DONE/ERR/IRQ_EN and irq (DMA_ADDR_AUTOINC_EN enables address chaining).
// Latency: read data one cycle after rd strobe, irq one cycle after DONE/IRQ_EN change; backpressure: none.
module dma_multi_ch_regs
  import dma_regs_pkg::*;
#(
  parameter int NUM_CH = 4,
  parameter int DATA_W = 32
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     cpu_wr_en,
  input  logic                     cpu_rd_en,
  input  logic [31:0]              cpu_addr,
  input  logic [DATA_W-1:0]        cpu_wr_data,
  output logic [DATA_W-1:0]        cpu_rd_data,
  output logic [NUM_CH*DATA_W-1:0] src_addr,
  output logic [NUM_CH*DATA_W-1:0] dstn_addr,
  output logic [NUM_CH*DATA_W-1:0] count,
  output logic [NUM_CH*DATA_W-1:0] ctrl_sig,
  output logic [NUM_CH-1:0]        ch_req,
  input  logic [NUM_CH-1:0]        ch_grant,
  input  logic [NUM_CH-1:0]        ch_done,
  output logic                     irq
);

  logic [3:0]        ch_idx, ch_off;
  logic              glb_sel;
  logic [NUM_CH-1:0] hw_done_set, hw_err_set;
  ch_state_e         ch_state [NUM_CH];

  logic [NUM_CH-1:0] done_q, done_d, err_q, err_d, irq_en_q, irq_en_d;
  logic [DATA_W-1:0] rd_data_q, rd_data_d, status;
  logic              irq_q, irq_d;
  logic              unused_addr_hi;

  assign ch_idx         = cpu_addr[7:4];
  assign ch_off         = cpu_addr[3:0];
  assign glb_sel        = cpu_addr[8];
  assign unused_addr_hi = ^cpu_addr[31:9];

  for (genvar n = 0; n < NUM_CH; n++) begin : g_ch
    dma_ch_regs #(.DATA_W(DATA_W)) u_ch (
      .clk      (clk),
      .reset    (reset),
      .wr_en    (cpu_wr_en && !glb_sel && ch_idx == 4'(n)),
      .wr_off   (ch_off),
      .wr_data  (cpu_wr_data),
      .grant    (ch_grant[n]),
      .done     (ch_done[n]),
      .src_addr (src_addr[n*DATA_W +: DATA_W]),
      .dstn_addr(dstn_addr[n*DATA_W +: DATA_W]),
      .count    (count[n*DATA_W +: DATA_W]),
      .ctrl_sig (ctrl_sig[n*DATA_W +: DATA_W]),
      .req      (ch_req[n]),
      .state    (ch_state[n]),
      .done_set (hw_done_set[n]),
      .err_set  (hw_err_set[n])
    );
  end

  always_comb begin
    status = '0;
    for (int n = 0; n < NUM_CH; n++) begin
      status[n]      = (ch_state[n] != CH_IDLE);
      status[16 + n] = (ch_state[n] == CH_BUSY);
    end
  end

  always_comb begin
    done_d   = done_q | hw_done_set;
    err_d    = err_q | hw_err_set;
    irq_en_d = irq_en_q;
    // Hardware sets are OR-ed after the W1C mask so they win a same-cycle clear.
    if (cpu_wr_en && cpu_addr[8:0] == ADDR_DONE)   done_d   = (done_q & ~cpu_wr_data[NUM_CH-1:0]) | hw_done_set;
    if (cpu_wr_en && cpu_addr[8:0] == ADDR_ERR)    err_d    = (err_q & ~cpu_wr_data[NUM_CH-1:0]) | hw_err_set;
    if (cpu_wr_en && cpu_addr[8:0] == ADDR_IRQ_EN) irq_en_d = cpu_wr_data[NUM_CH-1:0];
    irq_d = |(done_q & irq_en_q);
  end

  // Read mux samples only _q state, which gives read-old-data on a same-cycle write.
  always_comb begin
    rd_data_d = '0;
    if (cpu_rd_en) begin
      if (glb_sel) begin
        case (cpu_addr[8:0])
          ADDR_STATUS: rd_data_d = status;
          ADDR_DONE:   rd_data_d = DATA_W'(done_q);
          ADDR_ERR:    rd_data_d = DATA_W'(err_q);
          ADDR_IRQ_EN: rd_data_d = DATA_W'(irq_en_q);
          default:     rd_data_d = '0;
        endcase
      end else begin
        for (int n = 0; n < NUM_CH; n++) begin
          if (ch_idx == 4'(n)) begin
            case (ch_off)
              OFF_SRC:   rd_data_d = src_addr[n*DATA_W +: DATA_W];
              OFF_COUNT: rd_data_d = count[n*DATA_W +: DATA_W];
              OFF_CTRL:  rd_data_d = ctrl_sig[n*DATA_W +: DATA_W];
              OFF_DSTN:  rd_data_d = dstn_addr[n*DATA_W +: DATA_W];
              default:   rd_data_d = '0;
            endcase
          end
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      done_q    <= '0;
      err_q     <= '0;
      irq_en_q  <= '0;
      rd_data_q <= '0;
      irq_q     <= 1'b0;
    end else begin
      done_q    <= done_d;
      err_q     <= err_d;
      irq_en_q  <= irq_en_d;
      rd_data_q <= rd_data_d;
      irq_q     <= irq_d;
    end
  end

  assign cpu_rd_data = rd_data_q;
  assign irq         = irq_q;

endmodule

// File: tb/tb_dma_multi_ch_regs.sv
// Bench for dma_multi_ch_regs: directed register-map scenarios followed by random CPU/engine traffic against a reference model.
// Define DMA_ADDR_AUTOINC_EN for both RTL and bench to exercise address chaining.
module tb_dma_multi_ch_regs;
  localparam int NUM_CH = 4;
  localparam int DATA_W = 32;
  localparam int W      = NUM_CH * DATA_W;
  localparam int S_IDLE = 0, S_PEND = 1, S_BUSY = 2;

  logic              clk = 1'b0;
  logic              reset = 1'b1;
  logic              cpu_wr_en = 1'b0, cpu_rd_en = 1'b0;
  logic [31:0]       cpu_addr = '0;
  logic [DATA_W-1:0] cpu_wr_data = '0;
  logic [DATA_W-1:0] cpu_rd_data;
  logic [W-1:0]      src_addr, dstn_addr, count, ctrl_sig;
  logic [NUM_CH-1:0] ch_req;
  logic [NUM_CH-1:0] ch_grant = '0, ch_done = '0;
  logic              irq;

  int checks = 0;
  int errors = 0;

  dma_multi_ch_regs #(.NUM_CH(NUM_CH), .DATA_W(DATA_W)) dut (
    .clk(clk), .reset(reset), .cpu_wr_en(cpu_wr_en), .cpu_rd_en(cpu_rd_en),
    .cpu_addr(cpu_addr), .cpu_wr_data(cpu_wr_data), .cpu_rd_data(cpu_rd_data),
    .src_addr(src_addr), .dstn_addr(dstn_addr), .count(count), .ctrl_sig(ctrl_sig),
    .ch_req(ch_req), .ch_grant(ch_grant), .ch_done(ch_done), .irq(irq)
  );

  always #5 clk = ~clk;

  // Reference model: channel state plus register contents per channel.
  int          m_st  [NUM_CH];
  logic [31:0] m_src [NUM_CH];
  logic [31:0] m_dst [NUM_CH];
  logic [31:0] m_cnt [NUM_CH];
  logic [31:0] m_ctl [NUM_CH];
  logic [NUM_CH-1:0] m_done, m_err, m_irqen;
  logic [31:0] m_rd;
  logic        m_irq;

  task automatic chk(input string nm, input logic [W-1:0] act, input logic [W-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: actual=%h expected=%h at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] mread(input logic [31:0] a);
    logic [31:0] s;
    int c;
    s = 0;
    if (!a[8]) begin
      c = int'(a[7:4]);
      if (c >= NUM_CH) return 0;
      case (a[3:0])
        4'h0: return m_src[c];
        4'h4: return m_cnt[c];
        4'h8: return m_ctl[c];
        4'hC: return m_dst[c];
        default: return 0;
      endcase
    end
    case (a[7:0])
      8'h00: begin
        for (int k = 0; k < NUM_CH; k++) begin
          if (m_st[k] != S_IDLE) s = s + (32'd1 << k);
          if (m_st[k] == S_BUSY) s = s + (32'd1 << (16 + k));
        end
        return s;
      end
      8'h04: return 32'(m_done);
      8'h08: return 32'(m_err);
      8'h0C: return 32'(m_irqen);
      default: return 0;
    endcase
  endfunction

  task automatic model_step();
    logic [NUM_CH-1:0] dset, eset;
    logic [31:0] rd_next;
    logic irq_next, wr, mapped;
    logic [3:0] o;
    int pre;
    if (reset) begin
      for (int c = 0; c < NUM_CH; c++) begin
        m_st[c] = S_IDLE; m_src[c] = 0; m_dst[c] = 0; m_cnt[c] = 0; m_ctl[c] = 0;
      end
      m_done = 0; m_err = 0; m_irqen = 0; m_rd = 0; m_irq = 0;
      return;
    end
    rd_next  = cpu_rd_en ? mread(cpu_addr) : 32'd0;
    irq_next = |(m_done & m_irqen);
    dset = 0; eset = 0;
    o = cpu_addr[3:0];
    mapped = (o == 4'h0) || (o == 4'h4) || (o == 4'h8) || (o == 4'hC);
    for (int c = 0; c < NUM_CH; c++) begin
      pre = m_st[c];
      wr  = cpu_wr_en && !cpu_addr[8] && (int'(cpu_addr[7:4]) == c);
      if (pre == S_IDLE && wr) begin
        if (o == 4'h0) m_src[c] = cpu_wr_data;
        if (o == 4'h4) m_cnt[c] = cpu_wr_data;
        if (o == 4'hC) m_dst[c] = cpu_wr_data;
        if (o == 4'h8) begin
          m_ctl[c] = cpu_wr_data;
          if (cpu_wr_data[0]) m_st[c] = S_PEND;
        end
      end else if (pre == S_PEND) begin
        if (wr && o == 4'h8 && !cpu_wr_data[0]) begin
          m_ctl[c] = cpu_wr_data;
          m_st[c]  = S_IDLE;
        end else begin
          if (wr && mapped) eset[c] = 1'b1;
          if (ch_grant[c]) m_st[c] = S_BUSY;
        end
      end else if (pre == S_BUSY) begin
        if (wr && mapped) eset[c] = 1'b1;
        if (ch_done[c]) begin
          m_st[c]  = S_IDLE;
          m_ctl[c] = m_ctl[c] & ~32'd1;
          dset[c]  = 1'b1;
`ifdef DMA_ADDR_AUTOINC_EN
          if (m_ctl[c][2]) m_src[c] = m_src[c] + m_cnt[c] * 4;
          if (m_ctl[c][3]) m_dst[c] = m_dst[c] + m_cnt[c] * 4;
`endif
        end
      end
    end
    if (cpu_wr_en && cpu_addr[8:0] == 9'h104) m_done = m_done & ~cpu_wr_data[NUM_CH-1:0];
    if (cpu_wr_en && cpu_addr[8:0] == 9'h108) m_err  = m_err & ~cpu_wr_data[NUM_CH-1:0];
    if (cpu_wr_en && cpu_addr[8:0] == 9'h10C) m_irqen = cpu_wr_data[NUM_CH-1:0];
    m_done = m_done | dset;
    m_err  = m_err | eset;
    m_rd   = rd_next;
    m_irq  = irq_next;
  endtask

  task automatic compare_all();
    logic [W-1:0] es, ed, ec, et;
    logic [NUM_CH-1:0] er;
    for (int c = 0; c < NUM_CH; c++) begin
      es[c*32 +: 32] = m_src[c];
      ed[c*32 +: 32] = m_dst[c];
      ec[c*32 +: 32] = m_cnt[c];
      et[c*32 +: 32] = m_ctl[c];
      er[c] = (m_st[c] == S_PEND);
    end
    chk("model_src", src_addr, es);
    chk("model_dstn", dstn_addr, ed);
    chk("model_count", count, ec);
    chk("model_ctrl", ctrl_sig, et);
    chk("model_req", W'(ch_req), W'(er));
    chk("model_rd", W'(cpu_rd_data), W'(m_rd));
    chk("model_irq", W'(irq), W'(m_irq));
  endtask

  always @(posedge clk) begin
    model_step();
    #1;
    compare_all();
  end

  // Drives one cycle of inputs at the falling edge and returns just after the sampling edge.
  task automatic step(input logic we, input logic re, input logic [31:0] a, input logic [31:0] d,
                      input logic [3:0] g, input logic [3:0] dn, input logic rst);
    @(negedge clk);
    cpu_wr_en = we; cpu_rd_en = re; cpu_addr = a; cpu_wr_data = d;
    ch_grant = g; ch_done = dn; reset = rst;
    @(posedge clk);
    #2;
  endtask

  task automatic wr(input logic [31:0] a, input logic [31:0] d); step(1'b1, 1'b0, a, d, 4'h0, 4'h0, 1'b0); endtask
  task automatic rd(input logic [31:0] a); step(1'b0, 1'b1, a, 32'd0, 4'h0, 4'h0, 1'b0); endtask
  task automatic idle(); step(1'b0, 1'b0, 32'd0, 32'd0, 4'h0, 4'h0, 1'b0); endtask

  initial begin
    logic [31:0] a, d;
    int ch;
    logic [3:0] offs [6];
    logic [8:0] glbs [6];
    offs = '{4'h0, 4'h4, 4'h8, 4'hC, 4'h2, 4'h6};
    glbs = '{9'h100, 9'h104, 9'h108, 9'h10C, 9'h110, 9'h1F0};

    step(1'b0, 1'b0, 32'd0, 32'd0, 4'h0, 4'h0, 1'b1);
    step(1'b0, 1'b0, 32'd0, 32'd0, 4'h0, 4'h0, 1'b1);
    chk("rst_req", W'(ch_req), W'(0));
    chk("rst_irq", W'(irq), W'(0));
    chk("rst_rd", W'(cpu_rd_data), W'(0));
    chk("rst_src", src_addr, W'(0));

    // Program path on channel 1.
    wr(32'h010, 32'h1000); wr(32'h014, 32'h10); wr(32'h01C, 32'h2000); wr(32'h018, 32'h1);
    chk("prog_req", W'(ch_req), W'(4'b0010));
    rd(32'h100); chk("prog_status", W'(cpu_rd_data), W'(32'h0000_0002));
    rd(32'h010); chk("prog_src_rd", W'(cpu_rd_data), W'(32'h1000));
    idle();      chk("rd_idle_zero", W'(cpu_rd_data), W'(0));

    // Completion path with interrupt.
    wr(32'h10C, 32'h2);
    step(1'b0, 1'b0, 32'd0, 32'd0, 4'b0010, 4'h0, 1'b0);
    chk("grant_req_drop", W'(ch_req), W'(0));
    rd(32'h100); chk("busy_status", W'(cpu_rd_data), W'(32'h0002_0002));
    step(1'b0, 1'b0, 32'd0, 32'd0, 4'h0, 4'b0010, 1'b0);
    rd(32'h100); chk("done_status", W'(cpu_rd_data), W'(0));
    rd(32'h104); chk("done_reg", W'(cpu_rd_data), W'(32'h2));
    chk("irq_set", W'(irq), W'(1));
    wr(32'h104, 32'h2); idle();
    rd(32'h104); chk("done_w1c", W'(cpu_rd_data), W'(0));
    chk("irq_clr", W'(irq), W'(0));

    // Busy-write protection on channel 0.
    wr(32'h004, 32'h3); wr(32'h008, 32'h1);
    step(1'b0, 1'b0, 32'd0, 32'd0, 4'b0001, 4'h0, 1'b0);
    wr(32'h004, 32'h5);
    chk("busy_count_kept", W'(count[31:0]), W'(32'h3));
    rd(32'h108); chk("busy_err", W'(cpu_rd_data), W'(32'h1));
    step(1'b0, 1'b0, 32'd0, 32'd0, 4'h0, 4'b0001, 1'b0);
    wr(32'h104, 32'hF); wr(32'h108, 32'hF);

    // W1C of DONE[2] racing the hardware set.
    wr(32'h028, 32'h1);
    step(1'b0, 1'b0, 32'd0, 32'd0, 4'b0100, 4'h0, 1'b0);
    step(1'b1, 1'b0, 32'h104, 32'h4, 4'h0, 4'b0100, 1'b0);
    rd(32'h104); chk("w1c_race", W'(cpu_rd_data), W'(32'h4));
    wr(32'h104, 32'hF);

    // Cancel from PEND on channel 3.
    wr(32'h038, 32'h1);
    chk("cancel_req_on", W'(ch_req), W'(4'b1000));
    wr(32'h038, 32'h0);
    chk("cancel_req_off", W'(ch_req), W'(0));
    rd(32'h100); chk("cancel_status", W'(cpu_rd_data), W'(0));
    rd(32'h104); chk("cancel_done", W'(cpu_rd_data), W'(0));

    // Reset in the middle of a BUSY transfer, with a done in the reset cycle.
    wr(32'h018, 32'h1);
    step(1'b0, 1'b0, 32'd0, 32'd0, 4'b0010, 4'h0, 1'b0);
    step(1'b0, 1'b1, 32'h010, 32'd0, 4'h0, 4'b0010, 1'b1);
    chk("rst_busy_req", W'(ch_req), W'(0));
    chk("rst_busy_src", src_addr, W'(0));
    chk("rst_busy_ctrl", ctrl_sig, W'(0));
    chk("rst_busy_count", count, W'(0));
    chk("rst_busy_rd", W'(cpu_rd_data), W'(0));
    chk("rst_busy_irq", W'(irq), W'(0));
    rd(32'h104); chk("rst_done_lost", W'(cpu_rd_data), W'(0));

`ifdef DMA_ADDR_AUTOINC_EN
    wr(32'h000, 32'hFFFF_FFF0); wr(32'h004, 32'h4); wr(32'h008, 32'h5);
    step(1'b0, 1'b0, 32'd0, 32'd0, 4'b0001, 4'h0, 1'b0);
    step(1'b0, 1'b0, 32'd0, 32'd0, 4'h0, 4'b0001, 1'b0);
    chk("autoinc_wrap", W'(src_addr[31:0]), W'(0));
`endif

    // Random traffic checked cycle by cycle against the model.
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 1) == 0) begin
        ch = $urandom_range(0, NUM_CH);
        a  = {24'd0, 4'(ch), offs[$urandom_range(0, 5)]};
      end else begin
        a = {23'd0, glbs[$urandom_range(0, 5)]};
      end
      if ($urandom_range(0, 9) == 0) a[31:9] = 23'($urandom);
      d = $urandom;
      if ($urandom_range(0, 3) != 0) d[31:4] = '0;
      step($urandom_range(0, 9) < 3, $urandom_range(0, 9) < 4, a, d,
           4'($urandom_range(0, 15) & $urandom_range(0, 15)),
           4'($urandom_range(0, 15) & $urandom_range(0, 15)),
           $urandom_range(0, 199) == 0);
    end
    idle();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
